// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// The optional burst grant is enabled by defining FIFO_ARB_BURST_EN.
package fifo_write_arbiter_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 20;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Index following idx in a ring of n producers.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side handshake and FIFO write port of the arbiter.
// The slave modport is the arbiter; master is the producers plus the FIFO model.
interface fifo_write_arbiter_if
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    fifo_full;
    logic                    fifo_write;
    logic [DATA_W-1:0]       fifo_data;
    logic [IDX_W-1:0]        owner;
    logic                    busy;

    modport slave (
        input  req, req_data, fifo_full,
        output ack, fifo_write, fifo_data, owner, busy
    );

    modport master (
        output req, req_data, fifo_full,
        input  ack, fifo_write, fifo_data, owner, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan farthest-first so the slot closest to start is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                idx = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter placing N_REQ producers in front of one FIFO write port.
// Define FIFO_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST words.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                reset,
    fifo_write_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    arb_state_e       state, state_d;
    logic [IDX_W-1:0] owner, owner_d;
    logic [IDX_W-1:0] last_winner, last_d;
    logic [CNT_W-1:0] burst_cnt, cnt_d;

    logic [N_REQ-1:0]  ack_vec;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]  pick_base;
    logic [IDX_W-1:0]  pick_start;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    // From IDLE the scan follows the last winner; while owning it follows the owner,
    // which makes the current owner the lowest-priority candidate.
    assign pick_base  = (state == ST_IDLE) ? last_winner : owner;
    assign pick_start = IDX_W'(wrap_inc(int'(pick_base), N_REQ));

    rr_pick #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Gating with reset keeps a synchronous reset from letting a word slip through.
    always_comb begin
        ack_vec = '0;
        if (!reset && state == ST_OWN && bus.req[owner] && !bus.fifo_full) begin
            ack_vec[owner] = 1'b1;
        end
    end

    assign xfer     = |ack_vec;
    assign sel_data = bus.req_data[int'(owner)*DATA_W +: DATA_W];

    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d = state;
        owner_d = owner;
        last_d  = last_winner;
        cnt_d   = burst_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_OWN;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (xfer) begin
                    last_d = owner;
                    if (BURST_EN && burst_cnt < BURST_LAST) begin
                        cnt_d = burst_cnt + 1'b1;
                    end else begin
                        // req[owner] is set in a transfer cycle, so a pick always exists.
                        owner_d = pick_idx;
                        cnt_d   = '0;
                    end
                end else if (!bus.fifo_full && !bus.req[owner]) begin
                    cnt_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= '0;
            last_winner <= IDX_W'(N_REQ - 1);
            burst_cnt   <= '0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            last_winner <= last_d;
            burst_cnt   <= cnt_d;
        end
    end

    assign bus.ack        = ack_vec;
    assign bus.fifo_write = xfer;
    assign bus.fifo_data  = xfer ? sel_data : '0;
    assign bus.owner      = owner;
    assign bus.busy       = (state == ST_OWN);

    // Handshake invariants, ignored by synthesis.
    a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ack_vec));
    a_write_iff_ack: assert property (@(posedge clk) disable iff (reset)
        bus.fifo_write == (ack_vec != '0));
    a_no_write_full: assert property (@(posedge clk) disable iff (reset)
        bus.fifo_full |-> !bus.fifo_write);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, corner sequences and
// randomized traffic against a behavioural round-robin model.
module tb_fifo_write_arbiter;
    import fifo_write_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 20;
    localparam int MB = 4;

`ifdef FIFO_ARB_BURST_EN
    localparam int EXP_BURST = MB;
`else
    localparam int EXP_BURST = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    fifo_write_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pdata(input int i);
        return DW'(32'h12345 + i * 32'h01010);
    endfunction

    function automatic logic [N*DW-1:0] fixed_words();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = pdata(i);
        return v;
    endfunction

    // First requesting producer at or after start, wrapping; -1 if none.
    function automatic int first_from(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = fixed_words();
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] ack;
        logic [1:0]   owner;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    task automatic run_table();
        logic [DW-1:0] e_data;
        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            reset         = 1'b0;
            bus.req       = vecs[v].req;
            bus.fifo_full = vecs[v].full;
            bus.req_data  = fixed_words();
            #1;
            e_data = '0;
            for (int i = 0; i < N; i++) if (vecs[v].ack[i]) e_data = pdata(i);
            check($sformatf("vec%0d_ack", v),   bus.ack,        vecs[v].ack);
            check($sformatf("vec%0d_write", v), bus.fifo_write, |vecs[v].ack);
            check($sformatf("vec%0d_data", v),  bus.fifo_data,  e_data);
            check($sformatf("vec%0d_owner", v), bus.owner,      vecs[v].owner);
            check($sformatf("vec%0d_busy", v),  bus.busy,       vecs[v].busy);
        end
    endtask

    task automatic fill_fifo_test();
        int fifo_cnt = 0;
        int bad_writes = 0;
        int rem[N];
        for (int i = 0; i < N; i++) rem[i] = (i < 2) ? 8 : 0;
        do_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            reset         = 1'b0;
            for (int i = 0; i < N; i++) bus.req[i] = (rem[i] > 0);
            bus.fifo_full = (fifo_cnt >= 15);
            #1;
            if (bus.fifo_write) begin
                if (bus.fifo_full) bad_writes++;
                fifo_cnt++;
                for (int i = 0; i < N; i++) if (bus.ack[i]) rem[i]--;
            end
        end
        check("fill_accepted",   fifo_cnt,         15);
        check("fill_while_full", bad_writes,       0);
        check("fill_held_words", rem[0] + rem[1],  1);
        check("fill_busy",       bus.busy,         1'b1);
    endtask

    task automatic reset_mid_grant_test();
        do_reset();
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b1000;
        @(negedge clk);
        #1;
        check("rst_pre_owner", bus.owner, 2'd3);
        check("rst_pre_ack",   bus.ack,   4'b1000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_cycle_ack",   bus.ack,        4'b0000);
        check("rst_cycle_write", bus.fifo_write, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b1001;
        #1;
        check("rst_post_busy",  bus.busy,  1'b0);
        check("rst_post_owner", bus.owner, 2'd0);
        @(negedge clk);
        #1;
        check("rst_win_owner", bus.owner, 2'd0);
        check("rst_win_ack",   bus.ack,   4'b0001);
        check("rst_win_data",  bus.fifo_data, pdata(0));
    endtask

    task automatic random_test();
        bit            m_busy = 1'b0;
        int            m_owner = 0;
        int            m_last = N - 1;
        int            m_burst = 0;
        bit            p_pend[N];
        logic [DW-1:0] p_word[N];
        logic [N-1:0]  req_now;
        logic          rst_now;
        logic          full_now;
        logic [N-1:0]  e_ack;
        logic [DW-1:0] e_data;
        for (int i = 0; i < N; i++) begin
            p_pend[i] = 1'b0;
            p_word[i] = '0;
        end
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_now  = ($urandom_range(0, 99) == 0);
            full_now = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                if (!p_pend[i] && $urandom_range(0, 1) == 1) begin
                    p_pend[i] = 1'b1;
                    p_word[i] = DW'($urandom);
                end
                req_now[i] = p_pend[i];
                bus.req_data[i*DW +: DW] = p_word[i];
            end
            reset         = rst_now;
            bus.req       = req_now;
            bus.fifo_full = full_now;
            #1;
            e_ack  = '0;
            e_data = '0;
            if (!rst_now && m_busy && req_now[m_owner] && !full_now) begin
                e_ack[m_owner] = 1'b1;
                e_data         = p_word[m_owner];
            end
            check($sformatf("rnd%0d_ack", cyc),   bus.ack,        e_ack);
            check($sformatf("rnd%0d_write", cyc), bus.fifo_write, |e_ack);
            check($sformatf("rnd%0d_data", cyc),  bus.fifo_data,  e_data);
            check($sformatf("rnd%0d_owner", cyc), bus.owner,      m_owner);
            check($sformatf("rnd%0d_busy", cyc),  bus.busy,       m_busy);
            if (rst_now) begin
                m_busy  = 1'b0;
                m_owner = 0;
                m_last  = N - 1;
                m_burst = 0;
            end else if (!m_busy) begin
                if (req_now != '0) begin
                    m_owner = first_from(m_last + 1, req_now);
                    m_busy  = 1'b1;
                    m_burst = 0;
                end
            end else if (e_ack != '0) begin
                p_pend[m_owner] = 1'b0;
                m_last          = m_owner;
                if (m_burst < EXP_BURST - 1) begin
                    m_burst++;
                end else begin
                    m_owner = first_from(m_owner + 1, req_now);
                    m_burst = 0;
                end
            end else if (!full_now && !req_now[m_owner]) begin
                m_burst = 0;
                if (req_now != '0) m_owner = first_from(m_owner + 1, req_now);
                else m_busy = 1'b0;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = fixed_words();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_ack",   bus.ack,        4'b0000);
        check("reset_write", bus.fifo_write, 1'b0);
        check("reset_data",  bus.fifo_data,  '0);
        check("reset_owner", bus.owner,      2'd0);
        check("reset_busy",  bus.busy,       1'b0);

        // Rows: req, full, expected ack, owner, busy for one cycle each.
`ifdef FIFO_ARB_BURST_EN
        vecs.push_back('{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0});
        for (int k = 0; k < 4; k++) vecs.push_back('{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1});
        for (int k = 0; k < 4; k++) vecs.push_back('{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b0011, 1'b1, 4'b0000, 2'd1, 1'b1});
        for (int k = 0; k < 3; k++) vecs.push_back('{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
`else
        vecs.push_back('{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});
        vecs.push_back('{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1});
        vecs.push_back('{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1});
        vecs.push_back('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1});
        vecs.push_back('{4'b0101, 1'b0, 4'b0000, 2'd1, 1'b0});
        vecs.push_back('{4'b0101, 1'b1, 4'b0000, 2'd2, 1'b1});
        vecs.push_back('{4'b0101, 1'b1, 4'b0000, 2'd2, 1'b1});
        vecs.push_back('{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1});
        vecs.push_back('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
`endif
        run_table();
        fill_fifo_test();
        reset_mid_grant_test();
        random_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
